// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants: instruction width, PC stepping and reset address,
// kept next to the opcode/category definitions used by decode.
package fetch_queue_pkg;

   localparam int unsigned INSTR_WIDTH      = 32;
   localparam int unsigned PC_STEP_DEFAULT  = 4;
   localparam int unsigned RESET_PC_DEFAULT = 0;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'h03,
      OPC_IMM    = 7'h13,
      OPC_STORE  = 7'h23,
      OPC_OP     = 7'h33,
      OPC_BRANCH = 7'h63,
      OPC_JALR   = 7'h67,
      OPC_JAL    = 7'h6F
   } opcode_e;

   typedef enum logic [1:0] {
      CAT_ALU   = 2'd0,
      CAT_MEM   = 2'd1,
      CAT_CTRL  = 2'd2,
      CAT_OTHER = 2'd3
   } category_e;

   function automatic category_e opcode_category(input logic [6:0] opc);
      category_e cat;
      case (opc)
         OPC_IMM, OPC_OP:              cat = CAT_ALU;
         OPC_LOAD, OPC_STORE:          cat = CAT_MEM;
         OPC_BRANCH, OPC_JAL, OPC_JALR: cat = CAT_CTRL;
         default:                      cat = CAT_OTHER;
      endcase
      return cat;
   endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of {pc, instruction} pairs with wrapping pointers and a
// synchronous clear used to flush on a branch redirect.
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = INSTR_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      push,
   input  logic [ADDR_WIDTH-1:0]     push_pc,
   input  logic [DATA_WIDTH-1:0]     push_instruction,
   input  logic                      pop,
   output logic                      head_valid,
   output logic [ADDR_WIDTH-1:0]     head_pc,
   output logic [DATA_WIDTH-1:0]     head_instruction,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [ADDR_WIDTH-1:0] pc_mem_r    [DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic                  full_s;
   logic                  empty_s;
   logic                  do_push_s;
   logic                  do_pop_s;

   // Occupancy flags and guarded push/pop strobes.
   always_comb begin
      full_s    = (count_r == CW'(DEPTH));
      empty_s   = (count_r == {CW{1'b0}});
      do_push_s = push && !full_s;
      do_pop_s  = pop && !empty_s;
   end

   // Entry storage; contents are don't-care until counted as valid.
   always_ff @(posedge clock) begin
      if (do_push_s && !clear && !reset) begin
         pc_mem_r[wr_ptr_r]    <= push_pc;
         instr_mem_r[wr_ptr_r] <= push_instruction;
      end
   end

   // Pointer and occupancy update; clear drops all entries including a same-cycle push/pop.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   // Head presentation, forced to zero while empty.
   always_comb begin
      head_valid = !empty_s;
      count      = count_r;
      if (empty_s) begin
         head_pc          = {ADDR_WIDTH{1'b0}};
         head_instruction = {DATA_WIDTH{1'b0}};
      end else begin
         head_pc          = pc_mem_r[rd_ptr_r];
         head_instruction = instr_mem_r[rd_ptr_r];
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues in-order ROM reads under a credit limit,
// buffers responses with their PCs and flushes on redirect.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = INSTR_WIDTH,
   parameter int unsigned RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned PC_STEP    = PC_STEP_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  redirect_enable,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  rom_read_enable,
   output logic [ADDR_WIDTH-1:0] rom_read_address,
   input  logic                  rom_read_ready,
   input  logic                  rom_read_valid,
   input  logic [DATA_WIDTH-1:0] rom_read_data,
   output logic                  id_valid,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic [DATA_WIDTH-1:0] id_instruction,
   input  logic                  id_ready
);

   localparam int unsigned           CW         = $clog2(DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP_A  = ADDR_WIDTH'(PC_STEP);
   localparam logic [CW:0]           DEPTH_C    = (CW + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] fetch_pc_r;
   logic [ADDR_WIDTH-1:0] resp_pc_r;
   logic [CW-1:0]         inflight_r;
   logic [CW-1:0]         drop_r;
   logic [CW-1:0]         fifo_count_s;
   logic                  credit_ok_s;
   logic                  fire_s;
   logic                  drop_hit_s;
   logic                  push_s;
   logic                  pop_s;

   // Credit check uses registered occupancy, so a same-cycle pop frees nothing yet.
   always_comb begin
      credit_ok_s      = (({1'b0, fifo_count_s} + {1'b0, inflight_r}) < DEPTH_C);
      rom_read_enable  = !reset && !redirect_enable && credit_ok_s;
      rom_read_address = fetch_pc_r;
      fire_s           = rom_read_enable && rom_read_ready;
      drop_hit_s       = rom_read_valid && (drop_r != {CW{1'b0}});
      push_s           = rom_read_valid && !drop_hit_s && !redirect_enable;
      pop_s            = id_valid && id_ready && !redirect_enable;
   end

   // Issue/response bookkeeping; drop is recomputed from inflight on every redirect.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_r <= RESET_PC_A;
         resp_pc_r  <= RESET_PC_A;
         inflight_r <= {CW{1'b0}};
         drop_r     <= {CW{1'b0}};
      end else if (redirect_enable) begin
         fetch_pc_r <= redirect_pc;
         resp_pc_r  <= redirect_pc;
         inflight_r <= inflight_r - CW'(rom_read_valid);
         drop_r     <= inflight_r - CW'(rom_read_valid);
      end else begin
         if (fire_s) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP_A;
         end
         if (push_s) begin
            resp_pc_r <= resp_pc_r + PC_STEP_A;
         end
         if (drop_hit_s) begin
            drop_r <= drop_r - CW'(1);
         end
         inflight_r <= inflight_r + CW'(fire_s) - CW'(rom_read_valid);
      end
   end

   fetch_queue_fifo #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clock            (clock),
      .reset            (reset),
      .clear            (redirect_enable),
      .push             (push_s),
      .push_pc          (resp_pc_r),
      .push_instruction (rom_read_data),
      .pop              (pop_s),
      .head_valid       (id_valid),
      .head_pc          (id_pc),
      .head_instruction (id_instruction),
      .count            (fifo_count_s)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for streaming/backpressure/wrap,
// hand-written sequences for redirect and mid-traffic reset.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_enable = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        rom_read_enable;
   logic [31:0] rom_read_address;
   logic        rom_read_ready = 1'b1;
   logic        rom_read_valid = 1'b0;
   logic [31:0] rom_read_data = 32'h0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instruction;
   logic        id_ready = 1'b0;

   logic        rom_read_enable_w;
   logic [7:0]  rom_read_address_w;
   logic        rom_read_valid_w = 1'b0;
   logic [31:0] rom_read_data_w = 32'h0;
   logic        id_valid_w;
   logic [7:0]  id_pc_w;
   logic [31:0] id_instruction_w;

   int n_cmp = 0;
   int n_err = 0;
   int rom_lat = 1;

   always #5 clock = ~clock;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .redirect_enable(redirect_enable), .redirect_pc(redirect_pc),
      .rom_read_enable(rom_read_enable), .rom_read_address(rom_read_address),
      .rom_read_ready(rom_read_ready), .rom_read_valid(rom_read_valid),
      .rom_read_data(rom_read_data),
      .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instruction),
      .id_ready(id_ready)
   );

   fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(8), .RESET_PC(32'hF8)) dut_w (
      .clock(clock), .reset(reset),
      .redirect_enable(1'b0), .redirect_pc(8'h00),
      .rom_read_enable(rom_read_enable_w), .rom_read_address(rom_read_address_w),
      .rom_read_ready(1'b1), .rom_read_valid(rom_read_valid_w),
      .rom_read_data(rom_read_data_w),
      .id_valid(id_valid_w), .id_pc(id_pc_w), .id_instruction(id_instruction_w),
      .id_ready(1'b1)
   );

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic to_next();
      @(posedge clock);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) to_next();
   endtask

   // Two reset cycles, then release; caller is left in cycle 0.
   task automatic fresh(input int lat);
      reset = 1'b1;
      rom_lat = lat;
      redirect_enable = 1'b0;
      run(2);
      reset = 1'b0;
   endtask

   // ROM model with programmable fixed latency; responses return in order.
   logic [31:0] q_addr[$];
   int          q_due[$];
   int          rcyc = 0;
   logic        s_fire = 1'b0, s_rst = 1'b1, s_valid = 1'b0, s_fire_w = 1'b0;
   logic [31:0] s_addr = 32'h0;
   logic [7:0]  s_addr_w = 8'h0;

   always @(negedge clock) begin
      s_fire   = rom_read_enable && rom_read_ready;
      s_addr   = rom_read_address;
      s_rst    = reset;
      s_valid  = rom_read_valid;
      s_fire_w = rom_read_enable_w;
      s_addr_w = rom_read_address_w;
   end

   always @(posedge clock) begin
      #1;
      rcyc++;
      if (s_rst) begin
         q_addr.delete();
         q_due.delete();
      end else begin
         if (s_valid && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end
         if (s_fire) begin
            q_addr.push_back(s_addr);
            q_due.push_back(rcyc - 1 + rom_lat);
         end
      end
      if (q_addr.size() > 0 && q_due[0] <= rcyc) begin
         rom_read_valid = 1'b1;
         rom_read_data  = data_of(q_addr[0]);
      end else begin
         rom_read_valid = 1'b0;
         rom_read_data  = 32'h0;
      end
      rom_read_valid_w = s_fire_w && !s_rst;
      rom_read_data_w  = data_of({24'h0, s_addr_w});
   end

   // Credit and protocol invariants, watched every cycle out of reset.
   always @(negedge clock) begin
      if (!reset) begin
         chk("credit count+inflight<=DEPTH",
             64'(int'(dut.u_fifo.count_r) + int'(dut.inflight_r) <= DEPTH), 64'd1);
         chk("push into full queue", 64'(dut.push_s && (int'(dut.u_fifo.count_r) == DEPTH)), 64'd0);
         chk("response with nothing in flight", 64'(rom_read_valid && (dut.inflight_r == 3'd0)), 64'd0);
      end
   end

   typedef struct {
      logic        id_ready;
      logic        exp_en;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_wvalid;
      logic [7:0]  exp_wpc;
   } vec_t;

   vec_t tbl[16];

   initial begin
      // Steady stream c0..c4, backpressure c5..c9, release c10..c15; dut_w wraps F8->FC->00.
      tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 1'b1, 8'hF8};
      tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 1'b1, 8'hFC};
      tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 1'b1, 8'h00};
      tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 1'b1, 8'h04};
      tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C, 1'b1, 8'h08};
      tbl[7]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 1'b1, 8'h0C};
      tbl[8]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 1'b1, 8'h10};
      tbl[9]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 1'b1, 8'h14};
      tbl[10] = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C, 1'b1, 8'h18};
      tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 1'b1, 8'h1C};
      tbl[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 1'b1, 8'h20};
      tbl[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18, 1'b1, 8'h24};
      tbl[14] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C, 1'b1, 8'h28};
      tbl[15] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20, 1'b1, 8'h2C};

      // Reset state
      reset = 1'b1;
      run(2);
      @(negedge clock);
      chk("reset rom_read_enable", 64'(rom_read_enable), 64'd0);
      chk("reset id_valid", 64'(id_valid), 64'd0);
      chk("reset id_pc", 64'(id_pc), 64'd0);
      chk("reset id_instruction", 64'(id_instruction), 64'd0);
      chk("reset rom_read_address", 64'(rom_read_address), 64'd0);
      chk("reset wrap rom_read_address", 64'(rom_read_address_w), 64'hF8);
      to_next();
      reset = 1'b0;

      // Vector table
      for (int i = 0; i < 16; i++) begin
         id_ready = tbl[i].id_ready;
         @(negedge clock);
         chk($sformatf("A%0d rom_read_enable", i), 64'(rom_read_enable), 64'(tbl[i].exp_en));
         chk($sformatf("A%0d rom_read_address", i), 64'(rom_read_address), 64'(tbl[i].exp_addr));
         chk($sformatf("A%0d id_valid", i), 64'(id_valid), 64'(tbl[i].exp_valid));
         chk($sformatf("A%0d id_pc", i), 64'(id_pc), 64'(tbl[i].exp_pc));
         chk($sformatf("A%0d id_instruction", i), 64'(id_instruction),
             64'(tbl[i].exp_valid ? data_of(tbl[i].exp_pc) : 32'h0));
         chk($sformatf("A%0d wrap id_valid", i), 64'(id_valid_w), 64'(tbl[i].exp_wvalid));
         chk($sformatf("A%0d wrap id_pc", i), 64'(id_pc_w), 64'(tbl[i].exp_wpc));
         chk($sformatf("A%0d wrap id_instruction", i), 64'(id_instruction_w),
             64'(tbl[i].exp_wvalid ? data_of({24'h0, tbl[i].exp_wpc}) : 32'h0));
         to_next();
      end

      // Mid-traffic reset with a full queue
      fresh(1);
      id_ready = 1'b0;
      run(8);
      @(negedge clock);
      chk("E full id_valid", 64'(id_valid), 64'd1);
      chk("E full rom_read_enable", 64'(rom_read_enable), 64'd0);
      chk("E full count", 64'(dut.u_fifo.count_r), 64'd4);
      to_next();
      reset = 1'b1;
      @(negedge clock);
      chk("E reset-cycle rom_read_enable", 64'(rom_read_enable), 64'd0);
      to_next();
      reset = 1'b0;
      id_ready = 1'b1;
      @(negedge clock);
      chk("E post-reset id_valid", 64'(id_valid), 64'd0);
      chk("E post-reset id_pc", 64'(id_pc), 64'd0);
      chk("E post-reset id_instruction", 64'(id_instruction), 64'd0);
      chk("E post-reset rom_read_enable", 64'(rom_read_enable), 64'd1);
      chk("E post-reset rom_read_address", 64'(rom_read_address), 64'd0);
      run(2);
      @(negedge clock);
      chk("E first id_valid", 64'(id_valid), 64'd1);
      chk("E first id_pc", 64'(id_pc), 64'd0);
      chk("E first id_instruction", 64'(id_instruction), 64'(data_of(32'h0)));

      // Redirect with three requests in flight, ROM latency 3
      to_next();
      fresh(3);
      id_ready = 1'b1;
      run(3);
      redirect_enable = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clock);
      chk("B redirect rom_read_enable", 64'(rom_read_enable), 64'd0);
      to_next();
      redirect_enable = 1'b0;
      @(negedge clock);
      chk("B c4 drop", 64'(dut.drop_r), 64'd2);
      chk("B c4 rom_read_enable", 64'(rom_read_enable), 64'd1);
      chk("B c4 rom_read_address", 64'(rom_read_address), 64'h100);
      chk("B c4 id_valid", 64'(id_valid), 64'd0);
      for (int c = 5; c <= 7; c++) begin
         to_next();
         @(negedge clock);
         chk($sformatf("B c%0d id_valid", c), 64'(id_valid), 64'd0);
      end
      for (int k = 0; k < 2; k++) begin
         to_next();
         @(negedge clock);
         chk($sformatf("B c%0d id_valid", 8 + k), 64'(id_valid), 64'd1);
         chk($sformatf("B c%0d id_pc", 8 + k), 64'(id_pc), 64'(32'h100 + 32'(4 * k)));
         chk($sformatf("B c%0d id_instruction", 8 + k), 64'(id_instruction),
             64'(data_of(32'h100 + 32'(4 * k))));
      end

      // Redirect colliding with a response and a pop, ROM latency 2
      to_next();
      fresh(2);
      id_ready = 1'b1;
      run(4);
      redirect_enable = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clock);
      chk("C c4 id_pc before redirect", 64'(id_pc), 64'h4);
      chk("C c4 response present", 64'(rom_read_valid), 64'd1);
      chk("C c4 rom_read_enable", 64'(rom_read_enable), 64'd0);
      to_next();
      redirect_enable = 1'b0;
      @(negedge clock);
      chk("C c5 id_valid", 64'(id_valid), 64'd0);
      chk("C c5 drop", 64'(dut.drop_r), 64'd1);
      chk("C c5 rom_read_enable", 64'(rom_read_enable), 64'd1);
      chk("C c5 rom_read_address", 64'(rom_read_address), 64'h200);
      to_next();
      @(negedge clock);
      chk("C c6 id_valid", 64'(id_valid), 64'd0);
      chk("C c6 drop", 64'(dut.drop_r), 64'd0);
      to_next();
      @(negedge clock);
      chk("C c7 id_valid", 64'(id_valid), 64'd0);
      for (int k = 0; k < 2; k++) begin
         to_next();
         @(negedge clock);
         chk($sformatf("C c%0d id_valid", 8 + k), 64'(id_valid), 64'd1);
         chk($sformatf("C c%0d id_pc", 8 + k), 64'(id_pc), 64'(32'h200 + 32'(4 * k)));
         chk($sformatf("C c%0d id_instruction", 8 + k), 64'(id_instruction),
             64'(data_of(32'h200 + 32'(4 * k))));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
